sugar_ram_arb: RTL and testbench

SUGAR_RAM_ARB -- requirements
Module: sugar_ram_arb

---
 rtl/sugar_ram_pkg.sv | 31 +++
 rtl/sugar_rr_arb2.sv | 32 +++
 rtl/sugar_ram_arb.sv | 123 ++++++++++++
 tb/tb_sugar_ram_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sugar_ram_pkg.sv
// Shared types and constants for the sugar RAM arbiter: FSM state encoding,
// master index constants and the init-sequencing next-state helper.
package sugar_ram_pkg;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    RUN       = 2'd1,
    ERROR     = 2'd2
  } ram_state_e;

  localparam int unsigned M_IFETCH = 0;
  localparam int unsigned M_DATA   = 1;

  // ERROR and RUN are both absorbing; only WAIT_INIT looks at the init
  // handshake, and a reported error wins over a simultaneous done.
  function automatic ram_state_e ram_state_next(input ram_state_e cur,
                                                input logic       done,
                                                input logic       err);
    ram_state_e nxt;
    nxt = cur;
    if (cur == WAIT_INIT) begin
      if (err) begin
        nxt = ERROR;
      end else if (done) begin
        nxt = RUN;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sugar_rr_arb2.sv
// Two-way round-robin pick. ptr names the master that wins a tie; it moves to
// the other master whenever a grant is issued with upd_en high.
module sugar_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt,
  output logic       ptr
);

  // Grant is purely combinational so a lone requester is accepted the same cycle.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Favour whichever master was not granted last; hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (upd_en && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/sugar_ram_arb.sv
// Single-port RAM arbiter for the instruction-fetch (m0) and data (m1)
// masters. Grants are combinational, the RAM port follows the winner in the
// same cycle, and read data is steered back one cycle later using a
// registered owner tag so back-to-back reads to different masters stay ordered.
module sugar_ram_arb
  import sugar_ram_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ram_init_done,
  input  logic            i_ram_init_error,

  input  logic            i_m0_req,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_wdata,
  input  logic [DW/8-1:0] i_m0_wstrb,
  output logic            o_m0_gnt,
  output logic            o_m0_rvalid,
  output logic [DW-1:0]   o_m0_rdata,

  input  logic            i_m1_req,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_wdata,
  input  logic [DW/8-1:0] i_m1_wstrb,
  output logic            o_m1_gnt,
  output logic            o_m1_rvalid,
  output logic [DW-1:0]   o_m1_rdata,

  output logic            o_ram_en,
  output logic [DW/8-1:0] o_ram_we,
  output logic [AW-1:0]   o_ram_addr,
  output logic [DW-1:0]   o_ram_wdata,
  input  logic [DW-1:0]   i_ram_rdata,

  output logic            o_ram_ready,
  output logic            o_ram_err
);

  ram_state_e state_p0;
  logic       run;
  logic [1:0] arb_req;
  logic [1:0] arb_gnt;
  logic       unused_rr_ptr;
  logic       any_gnt;
  logic       sel_data;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [DW/8-1:0] win_wstrb;
  logic       rd_issue;
  logic       rvld_p1;
  logic       rown_p1;

  // Init sequencing: wait for the RAM, then run forever or park in ERROR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= WAIT_INIT;
    end else begin
      state_p0 <= ram_state_next(state_p0, i_ram_init_done, i_ram_init_error);
    end
  end

  // Reset is folded into the gating so every output is quiet while it is held,
  // including a read response that was already in flight.
  assign run         = (state_p0 == RUN) && !rst;
  assign o_ram_ready = run;
  assign o_ram_err   = (state_p0 == ERROR) && !rst;

  // Requests are only presented to the picker in RUN, so the pointer cannot
  // drift during init or error.
  assign arb_req = {i_m1_req, i_m0_req} & {2{run}};

  sugar_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .upd_en (run),
    .gnt    (arb_gnt),
    .ptr    (unused_rr_ptr)
  );

  assign o_m0_gnt = arb_gnt[M_IFETCH];
  assign o_m1_gnt = arb_gnt[M_DATA];
  assign any_gnt  = |arb_gnt;
  assign sel_data = arb_gnt[M_DATA];

  assign win_we    = sel_data ? i_m1_we    : i_m0_we;
  assign win_addr  = sel_data ? i_m1_addr  : i_m0_addr;
  assign win_wdata = sel_data ? i_m1_wdata : i_m0_wdata;
  assign win_wstrb = sel_data ? i_m1_wstrb : i_m0_wstrb;

  // Strobes only reach the RAM on writes; a read never writes even if the
  // master left wstrb non-zero.
  assign o_ram_en    = any_gnt;
  assign o_ram_we    = (any_gnt && win_we) ? win_wstrb : '0;
  assign o_ram_addr  = any_gnt ? win_addr  : '0;
  assign o_ram_wdata = any_gnt ? win_wdata : '0;

  assign rd_issue = any_gnt && !win_we;

  // ---- stage p0 -> p1: remember that a read was issued and for whom ----
  // Read-response tracking: one registered slot matches the RAM's one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvld_p1 <= 1'b0;
      rown_p1 <= 1'b0;
    end else begin
      rvld_p1 <= rd_issue;
      rown_p1 <= sel_data;
    end
  end

  assign o_m0_rvalid = rvld_p1 && !rown_p1 && !rst;
  assign o_m1_rvalid = rvld_p1 &&  rown_p1 && !rst;
  assign o_m0_rdata  = o_m0_rvalid ? i_ram_rdata : '0;
  assign o_m1_rdata  = o_m1_rvalid ? i_ram_rdata : '0;

endmodule

// File: tb/tb_sugar_ram_arb.sv
// Self-checking bench for sugar_ram_arb: a behavioural one-cycle RAM, a
// scoreboard of expected read responses, and directed init/fairness/
// ordering/byte-write/reset/error scenarios.
module tb_sugar_ram_arb;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, init_done, init_err;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ready, ram_err;

  sugar_ram_arb #(.AW(AW), .DW(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_ram_init_done  (init_done),
    .i_ram_init_error (init_err),
    .i_m0_req         (m0_req),
    .i_m0_we          (m0_we),
    .i_m0_addr        (m0_addr),
    .i_m0_wdata       (m0_wdata),
    .i_m0_wstrb       (m0_wstrb),
    .o_m0_gnt         (m0_gnt),
    .o_m0_rvalid      (m0_rvalid),
    .o_m0_rdata       (m0_rdata),
    .i_m1_req         (m1_req),
    .i_m1_we          (m1_we),
    .i_m1_addr        (m1_addr),
    .i_m1_wdata       (m1_wdata),
    .i_m1_wstrb       (m1_wstrb),
    .o_m1_gnt         (m1_gnt),
    .o_m1_rvalid      (m1_rvalid),
    .o_m1_rdata       (m1_rdata),
    .o_ram_en         (ram_en),
    .o_ram_we         (ram_we),
    .o_ram_addr       (ram_addr),
    .o_ram_wdata      (ram_wdata),
    .i_ram_rdata      (ram_rdata),
    .o_ram_ready      (ram_ready),
    .o_ram_err        (ram_err)
  );

  typedef struct {
    logic          m;
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_word(input int a);
    return {32'(a), 32'hA5A5_0000 ^ 32'(a)};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Behavioural single-port RAM: byte-masked write, registered read.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < SW; b++) begin
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  // Response monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if ((m == 0) ? m0_rvalid : m1_rvalid) begin
        if (sb_q.size() == 0) begin
          chk("rv_spurious", 1, 0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("rv_owner", m, sb_e.m);
          chk("rv_data", (m == 0) ? m0_rdata : m1_rdata, sb_e.d);
          chk("rv_cycle", cyc, sb_e.due);
        end
      end
    end
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      chk("rv_missing", 0, 1);
      void'(sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_rd(input logic m, input logic [DW-1:0] d);
    exp_t e;
    e.m = m; e.d = d; e.due = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic drv(input int m, input logic req, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, '0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(i);
    mem[13'h010] = 64'h1111_2222_3333_4444;
    mem[13'h011] = 64'hAAAA_BBBB_CCCC_DDDD;
    mem[13'h020] = 64'h0123_4567_89AB_CDEF;
    ram_rdata = '0;
    rst = 1'b1; init_done = 1'b0; init_err = 1'b0;
    idle();

    // Reset values
    repeat (3) tick();
    mid();
    chk("rst_ready", ram_ready, 0);
    chk("rst_err", ram_err, 0);
    chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("rst_en", ram_en, 0);

    // Init gating: both masters request while the RAM is not ready
    tick();
    rst = 1'b0;
    drv(0, 1, 0, 13'h010, '0, '0);
    drv(1, 1, 0, 13'h011, '0, '0);
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("init_gnt", {m1_gnt, m0_gnt}, 2'b00);
      chk("init_en", ram_en, 0);
      tick();
    end
    init_done = 1'b1;
    mid();
    chk("done_ready_early", ram_ready, 0);
    tick();
    mid();
    chk("done_ready", ram_ready, 1);
    chk("first_gnt", {m1_gnt, m0_gnt}, 2'b01);
    chk("first_addr", ram_addr, 13'h010);
    push_rd(0, 64'h1111_2222_3333_4444);
    tick();
    drv(0, 0, 0, '0, '0, '0);
    mid();
    chk("order_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("order_addr", ram_addr, 13'h011);
    push_rd(1, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    idle();
    mid();
    chk("idle_en", ram_en, 0);

    // Fairness: continuous requests alternate starting with m0
    tick();
    drv(0, 1, 0, 13'h030, '0, '0);
    drv(1, 1, 0, 13'h031, '0, '0);
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("fair_gnt", {m1_gnt, m0_gnt}, (i % 2) ? 2'b10 : 2'b01);
      chk("fair_addr", ram_addr, (i % 2) ? 13'h031 : 13'h030);
      push_rd(i % 2, init_word((i % 2) ? 'h031 : 'h030));
      tick();
    end
    idle();

    // Byte write from m1, then read back with stray strobes
    drv(1, 1, 1, 13'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    mid();
    chk("wr_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("wr_we", ram_we, 8'h0F);
    chk("wr_wdata", ram_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    drv(1, 1, 0, 13'h020, '0, 8'hFF);
    mid();
    chk("rdback_gnt", {m1_gnt, m0_gnt}, 2'b10);
    chk("rd_strb_we", ram_we, 8'h00);
    chk("rd_en", ram_en, 1);
    push_rd(1, 64'h0123_4567_FFFF_FFFF);
    tick();
    idle();
    mid();

    // Reset in the cycle after a read grant
    tick();
    drv(0, 1, 0, 13'h030, '0, '0);
    mid();
    chk("prerst_gnt", {m1_gnt, m0_gnt}, 2'b01);
    tick();
    rst = 1'b1; init_done = 1'b0;
    idle();
    mid();
    chk("rst_rv_cancel", {m1_rvalid, m0_rvalid}, 2'b00);
    tick();
    rst = 1'b0; init_done = 1'b1;
    drv(0, 1, 0, 13'h030, '0, '0);
    drv(1, 1, 0, 13'h031, '0, '0);
    mid();
    chk("postrst_rv", {m1_rvalid, m0_rvalid}, 2'b00);
    chk("postrst_ready", ram_ready, 0);
    chk("postrst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    tick();
    mid();
    chk("postrst_first", {m1_gnt, m0_gnt}, 2'b01);
    push_rd(0, init_word('h030));
    tick();
    idle();
    mid();

    // Error path: error and done together
    tick();
    rst = 1'b1; init_done = 1'b0;
    tick();
    rst = 1'b0; init_done = 1'b1; init_err = 1'b1;
    mid();
    chk("err_early", ram_err, 0);
    tick();
    drv(0, 1, 0, 13'h040, '0, '0);
    drv(1, 1, 1, 13'h041, '1, '1);
    for (int i = 0; i < 20; i++) begin
      mid();
      chk("err_flag", ram_err, 1);
      chk("err_ready", ram_ready, 0);
      chk("err_gnt", {m1_gnt, m0_gnt}, 2'b00);
      chk("err_en", ram_en, 0);
      tick();
    end
    rst = 1'b1;
    mid();
    tick();
    rst = 1'b0; init_done = 1'b0; init_err = 1'b0;
    idle();
    mid();
    chk("err_cleared", ram_err, 0);
    chk("err_rst_ready", ram_ready, 0);

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
